// File: rtl/sk6812_pkg.sv
// Shared types and constants for the SK6812RGBW frame transmitter.
// The optional SK6812_LOOP_EN build macro is consumed by sk6812_frame_tx.
package sk6812_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        HIGH = 3'd2,
        LOW  = 3'd3,
        GAP  = 3'd4
    } state_e;

    // Default bit timing in clock cycles for a 50 MHz system clock.
    localparam int unsigned DEF_T0H  = 32'd15;
    localparam int unsigned DEF_T1H  = 32'd30;
    localparam int unsigned DEF_TBIT = 32'd60;
    localparam int unsigned DEF_TRST = 32'd4000;

    localparam int unsigned WORD_W    = 32'd32;
    localparam int unsigned WORD_MSB  = 32'd31;
    localparam int unsigned BIT_IDX_W = 32'd5;

    typedef enum logic [1:0] {
        LANE_G = 2'd0,
        LANE_R = 2'd1,
        LANE_B = 2'd2,
        LANE_W = 2'd3
    } lane_e;

    localparam int unsigned LANE_G_LSB = 32'd24;
    localparam int unsigned LANE_R_LSB = 32'd16;
    localparam int unsigned LANE_B_LSB = 32'd8;
    localparam int unsigned LANE_W_LSB = 32'd0;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input lane_e lane);
        logic [31:0] sh;
        case (lane)
            LANE_G:  sh = word >> LANE_G_LSB;
            LANE_R:  sh = word >> LANE_R_LSB;
            LANE_B:  sh = word >> LANE_B_LSB;
            LANE_W:  sh = word >> LANE_W_LSB;
            default: sh = word;
        endcase
        return sh[7:0];
    endfunction

    function automatic int unsigned cnt_width(input int unsigned tbit, input int unsigned trst);
        int unsigned m;
        m = (tbit > trst) ? tbit : trst;
        return $clog2(m + 32'd1);
    endfunction

endpackage

// File: rtl/sk6812_frame_tx_if.sv
// Control and framebuffer-read bundle between the frame transmitter and its host/RAM.
interface sk6812_frame_tx_if #(
    parameter int unsigned ADDR_W = 6
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [31:0]       rd_data;
    logic              dout;

    modport master (
        output start,
        output rd_data,
        input  busy,
        input  done,
        input  rd_addr,
        input  dout
    );

    modport slave (
        input  start,
        input  rd_data,
        output busy,
        output done,
        output rd_addr,
        output dout
    );
endinterface

// File: rtl/sk6812_bit_timer.sv
// Cycle counter for one SK6812 bit period (high then low phase) or one low-only latch gap.
// load_i starts a bit, gap_i starts a TRST-long gap; bit_end_o marks the last cycle of either.
module sk6812_bit_timer
    import sk6812_pkg::*;
#(
    parameter int unsigned T0H  = DEF_T0H,
    parameter int unsigned T1H  = DEF_T1H,
    parameter int unsigned TBIT = DEF_TBIT,
    parameter int unsigned TRST = DEF_TRST
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic bit_i,
    input  logic gap_i,
    output logic dout_o,
    output logic high_end_o,
    output logic bit_end_o
);
    localparam int unsigned CNT_W = cnt_width(TBIT, TRST);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(TBIT - 32'd1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(TRST - 32'd1);
    localparam logic [CNT_W-1:0] T0_LAST  = CNT_W'(T0H - 32'd1);
    localparam logic [CNT_W-1:0] T1_LAST  = CNT_W'(T1H - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] lim_q;
    logic [CNT_W-1:0] hi_last_q;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [CNT_W-1:0] new_hi_last_s;
    logic             run_q;
    logic             is_bit_q;
    logic             dout_q;
    logic             high_end_q;
    logic             bit_end_q;

    assign cnt_inc_s     = cnt_q + CNT_W'(1);
    assign new_hi_last_s = bit_i ? T1_LAST : T0_LAST;

    // Period counter; all phase flags are computed one cycle ahead so they come straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            lim_q      <= '0;
            hi_last_q  <= '0;
            run_q      <= 1'b0;
            is_bit_q   <= 1'b0;
            dout_q     <= 1'b0;
            high_end_q <= 1'b0;
            bit_end_q  <= 1'b0;
        end else if (load_i) begin
            cnt_q      <= '0;
            lim_q      <= BIT_LAST;
            hi_last_q  <= new_hi_last_s;
            run_q      <= 1'b1;
            is_bit_q   <= 1'b1;
            dout_q     <= 1'b1;
            high_end_q <= (new_hi_last_s == '0);
            bit_end_q  <= 1'b0;
        end else if (gap_i) begin
            cnt_q      <= '0;
            lim_q      <= GAP_LAST;
            hi_last_q  <= '0;
            run_q      <= 1'b1;
            is_bit_q   <= 1'b0;
            dout_q     <= 1'b0;
            high_end_q <= 1'b0;
            bit_end_q  <= (GAP_LAST == '0);
        end else if (run_q && !bit_end_q) begin
            cnt_q      <= cnt_inc_s;
            dout_q     <= is_bit_q && (cnt_inc_s <= hi_last_q);
            high_end_q <= is_bit_q && (cnt_inc_s == hi_last_q);
            bit_end_q  <= (cnt_inc_s == lim_q);
        end else begin
            run_q      <= 1'b0;
            dout_q     <= 1'b0;
            high_end_q <= 1'b0;
            bit_end_q  <= 1'b0;
        end
    end

    assign dout_o     = dout_q;
    assign high_end_o = high_end_q;
    assign bit_end_o  = bit_end_q;

endmodule

// File: rtl/sk6812_frame_tx.sv
// SK6812RGBW frame transmitter: streams NUM_LEDS framebuffer words MSB first, then a latch gap.
// Build macro SK6812_LOOP_EN: restart the frame automatically after every latch gap.
module sk6812_frame_tx
    import sk6812_pkg::*;
#(
    parameter int unsigned NUM_LEDS = 35,
    parameter int unsigned ADDR_W   = 6,
    parameter int unsigned T0H      = DEF_T0H,
    parameter int unsigned T1H      = DEF_T1H,
    parameter int unsigned TBIT     = DEF_TBIT,
    parameter int unsigned TRST     = DEF_TRST
) (
    input logic         clk,
    input logic         rst_n,
    sk6812_frame_tx_if.slave bus
);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_LEDS - 32'd1);
    localparam logic [ADDR_W:0]   LAST_WIDE  = (ADDR_W + 1)'(NUM_LEDS - 32'd1);
    localparam logic [ADDR_W-1:0] FIRST_NEXT = (NUM_LEDS > 32'd1) ? ADDR_W'(1) : '0;

    state_e                 state_q;
    // Bits still to send in the current word; the bit on the wire lives in the timer.
    logic [WORD_MSB-1:0]    rest_q;
    logic [ADDR_W-1:0]      led_idx_q;
    logic [BIT_IDX_W-1:0]   bit_idx_q;
    logic [ADDR_W-1:0]      rd_addr_q;
    logic                   busy_q;
    logic                   done_q;

    logic                   tmr_load_s;
    logic                   tmr_bit_s;
    logic                   tmr_gap_s;
    logic                   tmr_dout_s;
    logic                   tmr_high_end_s;
    logic                   tmr_bit_end_s;
    logic                   last_bit_s;
    logic                   last_led_s;
    logic [ADDR_W:0]        addr_inc_s;
    logic [ADDR_W-1:0]      next_addr_s;

    assign last_bit_s = (bit_idx_q == 5'd0);
    assign last_led_s = (led_idx_q == LAST_IDX);
    assign addr_inc_s = {1'b0, led_idx_q} + (ADDR_W + 1)'(2);

    // Prefetch address for the word after the one being loaded, clamped at the last LED.
    always_comb begin
        if (addr_inc_s > LAST_WIDE) begin
            next_addr_s = LAST_IDX;
        end else begin
            next_addr_s = addr_inc_s[ADDR_W-1:0];
        end
    end

    // Timer kicks: a new bit starts on the same edge the FSM consumes the previous bit_end.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_bit_s  = 1'b0;
        tmr_gap_s  = 1'b0;
        case (state_q)
            LOAD: begin
                tmr_load_s = 1'b1;
                tmr_bit_s  = bus.rd_data[WORD_MSB];
            end
            LOW: begin
                if (tmr_bit_end_s) begin
                    if (!last_bit_s) begin
                        tmr_load_s = 1'b1;
                        tmr_bit_s  = rest_q[WORD_MSB-1];
                    end else if (!last_led_s) begin
                        tmr_load_s = 1'b1;
                        tmr_bit_s  = bus.rd_data[WORD_MSB];
                    end else begin
                        tmr_gap_s  = 1'b1;
                    end
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            default: begin
                tmr_load_s = 1'b0;
            end
        endcase
    end

    sk6812_bit_timer #(
        .T0H  (T0H),
        .T1H  (T1H),
        .TBIT (TBIT),
        .TRST (TRST)
    ) u_bit_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load_s),
        .bit_i      (tmr_bit_s),
        .gap_i      (tmr_gap_s),
        .dout_o     (tmr_dout_s),
        .high_end_o (tmr_high_end_s),
        .bit_end_o  (tmr_bit_end_s)
    );

    // Frame sequencer: word/bit indices, prefetch address and host status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rest_q    <= '0;
            led_idx_q <= '0;
            bit_idx_q <= '0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rd_addr_q <= '0;
                    // A start coinciding with the done pulse is dropped.
                    if (bus.start && !done_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                LOAD: begin
                    rest_q    <= bus.rd_data[WORD_MSB-1:0];
                    led_idx_q <= '0;
                    bit_idx_q <= 5'd31;
                    rd_addr_q <= FIRST_NEXT;
                    state_q   <= HIGH;
                end
                HIGH: begin
                    if (tmr_high_end_s) begin
                        state_q <= LOW;
                    end else begin
                        state_q <= HIGH;
                    end
                end
                LOW: begin
                    if (tmr_bit_end_s) begin
                        if (!last_bit_s) begin
                            rest_q    <= {rest_q[WORD_MSB-2:0], 1'b0};
                            bit_idx_q <= bit_idx_q - 5'd1;
                            state_q   <= HIGH;
                        end else if (!last_led_s) begin
                            rest_q    <= bus.rd_data[WORD_MSB-1:0];
                            led_idx_q <= led_idx_q + ADDR_W'(1);
                            bit_idx_q <= 5'd31;
                            rd_addr_q <= next_addr_s;
                            state_q   <= HIGH;
                        end else begin
                            // Point back at word 0 early so it is ready for the next LOAD.
                            rd_addr_q <= '0;
                            state_q   <= GAP;
                        end
                    end else begin
                        state_q <= LOW;
                    end
                end
                GAP: begin
                    if (tmr_bit_end_s) begin
                        done_q    <= 1'b1;
                        rd_addr_q <= '0;
`ifdef SK6812_LOOP_EN
                        state_q   <= LOAD;
                        busy_q    <= 1'b1;
`else
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
`endif
                    end else begin
                        state_q <= GAP;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_addr = rd_addr_q;
    assign bus.dout    = tmr_dout_s;

endmodule

// File: tb/tb_sk6812_frame_tx.sv
// Self-checking bench: a 2-LED instance with a decoding monitor/scoreboard, plus a 64-LED instance.
module tb_sk6812_frame_tx;
    localparam int NL  = 2;
    localparam int NLB = 64;
    localparam int AW  = 6;
    localparam int T0  = 2;
    localparam int T1  = 4;
    localparam int TB  = 6;
    localparam int TR  = 20;
    localparam int FRAME_LEN   = 1 + NL * 32 * TB + TR;
    localparam int FRAME_LEN_B = 1 + NLB * 32 * TB + TR;

    typedef struct {
        logic [31:0] w0;
        logic [31:0] w1;
        int          rp1;
        int          rp2;
        int          exp_len;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic exp_q[$];
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sk6812_frame_tx_if #(.ADDR_W(AW)) bus_a ();
    sk6812_frame_tx_if #(.ADDR_W(AW)) bus_b ();

    sk6812_frame_tx #(.NUM_LEDS(NL), .ADDR_W(AW), .T0H(T0), .T1H(T1), .TBIT(TB), .TRST(TR))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    sk6812_frame_tx #(.NUM_LEDS(NLB), .ADDR_W(AW), .T0H(T0), .T1H(T1), .TBIT(TB), .TRST(TR))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Framebuffer port models: registered read, one cycle of latency.
    always @(posedge clk) begin
        bus_a.rd_data <= mem_a[bus_a.rd_addr];
        bus_b.rd_data <= mem_b[bus_b.rd_addr];
    end

    function automatic void chk(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Line decoder: measures high widths and bit periods, compares against the scoreboard.
    int hi_cnt = 0;
    int lo_cnt = 0;
    int since_rise = 1000;
    always @(negedge clk) begin
        logic eb;
        if (!rst_n) begin
            hi_cnt = 0;
            lo_cnt = 0;
            since_rise = 1000;
        end else begin
            if (bus_a.dout) begin
                if (hi_cnt == 0) begin
                    if (since_rise <= 2 * TB) chk("bit_period", since_rise == TB, since_rise, TB);
                    else if (since_rise < 1000) chk("latch_gap_low", lo_cnt >= TR, lo_cnt, TR);
                    since_rise = 0;
                end
                hi_cnt++;
                lo_cnt = 0;
            end else begin
                if (hi_cnt != 0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_bit", 1'b0, hi_cnt, 0);
                    end else begin
                        eb = exp_q.pop_front();
                        chk("high_width", hi_cnt == (eb ? T1 : T0), hi_cnt, eb ? T1 : T0);
                    end
                    hi_cnt = 0;
                end
                lo_cnt++;
            end
            if (since_rise < 1000) since_rise++;
        end
    end

    task automatic push_frame(input logic [31:0] w0, input logic [31:0] w1);
        mem_a[0] = w0;
        mem_a[1] = w1;
        for (int i = 31; i >= 0; i--) exp_q.push_back(w0[i]);
        for (int i = 31; i >= 0; i--) exp_q.push_back(w1[i]);
    endtask

    task automatic kick(output int e0);
        @(negedge clk);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        e0 = cyc;
    endtask

    task automatic wait_done(input int e0, input int budget, input int rp1, input int rp2,
                             output int len, output int busy_lo, output int max_addr);
        len = -1;
        busy_lo = 0;
        max_addr = 0;
        while (len < 0 && (cyc - e0) < budget) begin
            @(negedge clk);
            bus_a.start = ((cyc - e0) == rp1) || ((cyc - e0) == rp2);
            if (bus_a.done) len = cyc - e0;
            else if (!bus_a.busy) busy_lo++;
            if (int'(bus_a.rd_addr) > max_addr) max_addr = int'(bus_a.rd_addr);
        end
        bus_a.start = 1'b0;
        if (len < 0) chk("done_timeout", 1'b0, cyc - e0, budget);
    endtask

    task automatic start_checks();
        chk("busy_after_start", bus_a.busy == 1'b1, bus_a.busy, 1);
        chk("dout_low_in_load", bus_a.dout == 1'b0, bus_a.dout, 0);
        @(negedge clk);
        chk("dout_rise_after_load", bus_a.dout == 1'b1, bus_a.dout, 1);
    endtask

    task automatic after_frame();
        int nd;
        chk("busy_falls_with_done", bus_a.busy == 1'b0, bus_a.busy, 0);
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus_a.done) nd++;
        end
        chk("done_single_pulse", nd == 0, nd, 0);
        chk("bits_consumed", exp_q.size() == 0, exp_q.size(), 0);
        chk("idle_rd_addr", bus_a.rd_addr == '0, int'(bus_a.rd_addr), 0);
    endtask

    initial begin
        vec_t vecs[4];
        int e0, len, blo, maxa;
        vecs[0] = '{32'h8000_0001, 32'h0000_0000, -1, -1, FRAME_LEN};
        vecs[1] = '{32'hFFFF_FFFF, 32'hA5A5_A5A5, -1, -1, FRAME_LEN};
        vecs[2] = '{32'h0F1E_2D3C, 32'hC3B4_A596, 10, 200, FRAME_LEN};
        vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, -1, -1, FRAME_LEN};
        for (int i = 0; i < 64; i++) begin
            mem_a[i] = 32'h0;
            mem_b[i] = 32'h0102_0304 * (i + 1) ^ 32'hC0DE_0000;
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_dout", bus_a.dout == 1'b0, bus_a.dout, 0);
        chk("rst_busy", bus_a.busy == 1'b0, bus_a.busy, 0);
        chk("rst_done", bus_a.done == 1'b0, bus_a.done, 0);
        chk("rst_rd_addr", bus_a.rd_addr == '0, int'(bus_a.rd_addr), 0);
        #2 rst_n = 1'b1;

`ifdef SK6812_LOOP_EN
        for (int f = 0; f < 4; f++) push_frame(32'h8000_0001, 32'h0000_0000);
        kick(e0);
        start_checks();
        for (int f = 1; f <= 3; f++) begin
            wait_done(e0, f * FRAME_LEN + 40, -1, -1, len, blo, maxa);
            chk("loop_done_time", len == f * FRAME_LEN, len, f * FRAME_LEN);
            chk("loop_busy_held", blo == 0, blo, 0);
            chk("loop_busy_at_done", bus_a.busy == 1'b1, bus_a.busy, 1);
        end
`else
        foreach (vecs[v]) begin
            push_frame(vecs[v].w0, vecs[v].w1);
            kick(e0);
            start_checks();
            wait_done(e0, vecs[v].exp_len + 40, vecs[v].rp1, vecs[v].rp2, len, blo, maxa);
            chk("frame_len", len == vecs[v].exp_len, len, vecs[v].exp_len);
            chk("busy_held", blo == 0, blo, 0);
            chk("rd_addr_max", maxa == NL - 1, maxa, NL - 1);
            after_frame();
        end

        // start during the done cycle is dropped, the next cycle's start is taken
        push_frame(32'h1234_5678, 32'h9ABC_DEF0);
        kick(e0);
        wait_done(e0, FRAME_LEN + 40, -1, -1, len, blo, maxa);
        chk("frame_len_pre_done", len == FRAME_LEN, len, FRAME_LEN);
        push_frame(32'hDEAD_BEEF, 32'h0123_4567);
        bus_a.start = 1'b1;
        @(negedge clk);
        chk("start_in_done_ignored", bus_a.busy == 1'b0, bus_a.busy, 0);
        @(negedge clk);
        bus_a.start = 1'b0;
        e0 = cyc;
        chk("start_after_done_taken", bus_a.busy == 1'b1, bus_a.busy, 1);
        wait_done(e0, FRAME_LEN + 40, -1, -1, len, blo, maxa);
        chk("frame_len_back_to_back", len == FRAME_LEN, len, FRAME_LEN);
        after_frame();

        // reset in the middle of word 0
        push_frame(32'hFFFF_0000, 32'h5555_AAAA);
        kick(e0);
        while ((cyc - e0) < 150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_dout", bus_a.dout == 1'b0, bus_a.dout, 0);
        chk("midrst_busy", bus_a.busy == 1'b0, bus_a.busy, 0);
        chk("midrst_rd_addr", bus_a.rd_addr == '0, int'(bus_a.rd_addr), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        push_frame(32'h8000_0001, 32'h7F00_00FE);
        kick(e0);
        start_checks();
        wait_done(e0, FRAME_LEN + 40, -1, -1, len, blo, maxa);
        chk("frame_len_after_rst", len == FRAME_LEN, len, FRAME_LEN);
        after_frame();

        // 64-LED instance: address saturates at 63 and only returns to 0 once the gap starts
        begin
            int lenb, maxb, zero_k;
            bit seen_nz;
            lenb = -1; maxb = 0; zero_k = -1; seen_nz = 1'b0;
            @(negedge clk);
            bus_b.start = 1'b1;
            @(negedge clk);
            bus_b.start = 1'b0;
            e0 = cyc;
            while (lenb < 0 && (cyc - e0) < FRAME_LEN_B + 40) begin
                @(negedge clk);
                if (bus_b.done) lenb = cyc - e0;
                if (int'(bus_b.rd_addr) > maxb) maxb = int'(bus_b.rd_addr);
                if (bus_b.rd_addr != '0) seen_nz = 1'b1;
                else if (seen_nz && zero_k < 0) zero_k = cyc - e0;
            end
            chk("b_frame_len", lenb == FRAME_LEN_B, lenb, FRAME_LEN_B);
            chk("b_rd_addr_max", maxb == NLB - 1, maxb, NLB - 1);
            chk("b_no_wrap_before_gap", zero_k >= 1 + NLB * 32 * TB, zero_k, 1 + NLB * 32 * TB);
            chk("b_busy_falls", bus_b.busy == 1'b0, bus_b.busy, 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sk6812_frame_tx.md
# sk6812_frame_tx

Frame transmitter for the SK6812RGBW LED string. It reads one 32-bit RGBW word per LED from the second, read-only port of the pixel framebuffer RAM and serializes each word onto the single-wire LED data line using SK6812 pulse-width encoding. After the last LED it holds a latch/reset gap. The Wishbone side writes the RAM; this block is the consumer at the other end of that RAM.

## Interface
- NUM_LEDS, 35: words per frame; legal range is 1 to 2**ADDR_W.
- ADDR_W, 6: width of the framebuffer address.
- T0H, 15: high cycles for a 0 bit (0.3 µs at 50 MHz).
- T1H, 30: high cycles for a 1 bit (0.6 µs).
- TBIT, 60: total cycles per bit (1.2 µs). Must satisfy TBIT > T1H > T0H ≥ 1.
- TRST, 4000: low cycles of the latch gap (80 µs).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle frame request.
- busy  out  1  high from start acceptance until the end of the latch gap.
- done  out  1  one-cycle pulse when the latch gap ends.
- rd_addr  out  ADDR_W  framebuffer read address; drives the RAM second read address.
- rd_data  in  32  framebuffer read data; registered RAM output, 1-cycle latency.
- dout  out  1  LED data line; registered, glitch-free.

## Operation
- Word format is {G[31:24], R[23:16], B[15:8], W[7:0]}, sent MSB first (bit 31 first). Software packs the word; this block does no reordering.
- States:
  - IDLE: rd_addr=0, dout=0, busy=0. start → LOAD.
  - LOAD: 1 cycle. Latch rd_data into the shift register, set led_idx=0, bit_idx=31, rd_addr←1 → HIGH.
  - HIGH: dout=1 for T1H cycles if the current MSB is 1, otherwise T0H cycles → LOW.
  - LOW: dout=0 for the remaining TBIT−Thigh cycles. At the end of LOW:
    - If bits remain: shift left, bit_idx−1 → HIGH.
    - If the word is finished and LEDs remain: load rd_data into the shift register, led_idx+1, rd_addr←led_idx+2 (saturating, no wrap past NUM_LEDS−1) → HIGH.
    - If the last LED is finished → GAP.
  - GAP: dout=0 for TRST cycles, then done=1 for 1 cycle, rd_addr←0 → IDLE.
- Prefetch: rd_addr points at the next word throughout the current word, so rd_data is stable long before it is loaded. There is no inter-word gap; bit cadence is exactly TBIT throughout the frame.
- start while busy is ignored; there is no queuing.
- Counters:
  - Timing counter is $clog2(max(TBIT,TRST)+1) bits.
  - led_idx is ADDR_W bits.
  - bit_idx is 5 bits.
- Reset mid-frame: outputs return to reset values immediately and the partial frame is abandoned. The LEDs latch garbage until the next full frame; this is accepted.
- Reset values: dout=0, busy=0, done=0, rd_addr=0, state=IDLE.

## Timing
- start is sampled at edge E0 and moves the block to LOAD, with busy=1 after E0.
- The shift register loads at E1, and dout rises after E1.
- Frame duration from E0 to the done pulse is 1 + NUM_LEDS·32·TBIT + TRST cycles.
- done is asserted for exactly one cycle. busy falls in the same cycle done is asserted.
- A start in the done cycle is ignored. A start on the next cycle is accepted.
- Each bit period is exactly TBIT cycles with no jitter.

## Configuration
- SK6812_LOOP_EN defined: at the end of GAP the block re-enters LOAD automatically (continuous refresh). done still pulses every frame, busy stays 1 after the first start, and start is ignored after the first frame.
- SK6812_LOOP_EN undefined: one frame per accepted start, as described above.

## Structure
- Package sk6812_pkg holds:
  - the state enum (IDLE, LOAD, HIGH, LOW, GAP);
  - default timing constants for 50 MHz (T0H/T1H/TBIT/TRST);
  - the word byte-lane positions.
- One sub-module, sk6812_bit_timer, owns the cycle counter and the high/low phase:
  - inputs: load pulse, bit value;
  - outputs: dout level and bit_end pulse.
- The top-level FSM owns the shift register, the indices and rd_addr.

## Test plan
Bench parameters: NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRST=20, driven from a 1-cycle-latency RAM model.

- Word 0 = 0x80000001, word 1 = 0x00000000, start pulse:
  - bit 31 is high for 4 cycles then low for 2;
  - bits 30..1 are high 2 / low 4;
  - bit 0 is high 4;
  - the frame spans 1+384+20=405 cycles, and done pulses once.
- Word 0 = 0xFFFFFFFF, word 1 = 0xA5A5A5A5: the captured bit stream decodes back to exactly both words in order, rd_addr never exceeds 1, and there is no gap between words.
- start re-pulsed at cycles 10 and 200 while busy: no effect, and the frame length is still 405.
- rst_n asserted at cycle 150 mid-word:
  - dout=0, busy=0 and rd_addr=0 immediately;
  - a new start then produces a complete 405-cycle frame.
- With SK6812_LOOP_EN defined and a single start: done pulses at cycles 405, 810 and 1215, dout stays low for 20 cycles before each new frame, and busy stays 1.
- NUM_LEDS=64, ADDR_W=6: rd_addr reaches 63 and saturates with no wrap to 0 before GAP, and done follows after 64 words.
